// File: rtl/fft_butterfly_pipe.sv
// Pipelined radix-2 DIT butterfly: X = A + B*W, Y = A - B*W.
// Four register stages, global stall, saturating scaled outputs.
module fft_butterfly_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic [1:0]    in_scale,
  input  logic [DW-1:0] ar,
  input  logic [DW-1:0] ai,
  input  logic [DW-1:0] br,
  input  logic [DW-1:0] bi,
  input  logic [TW-1:0] wr,
  input  logic [TW-1:0] wi,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] xr,
  output logic [DW-1:0] xi,
  output logic [DW-1:0] yr,
  output logic [DW-1:0] yi,
  output logic          out_ovf,
  output logic          ovf_sticky,
  input  logic          clr_ovf
);

  localparam int PW = DW + TW;
  localparam int SW = DW + TW + 1;
  localparam int ZW = DW + 2;
  localparam int FW = DW + 3;
  localparam int VW = DW + 4;

  localparam logic signed [SW-1:0] ZHALF =
    {{(SW-TW+1){1'b0}}, 1'b1, {(TW-2){1'b0}}};
  localparam logic signed [VW-1:0] MAXV =
    {{(VW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [VW-1:0] MINV =
    {{(VW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [VW-1:0] ONE = 1;
  localparam logic signed [VW-1:0] TWO = 2;

  // Global stall: everything moves only when the output slot frees.
  logic en;
  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // ---------------- S1: registered inputs ----------------
  logic                 s1_valid;
  logic                 s1_inv;
  logic [1:0]           s1_shift;
  logic signed [DW-1:0] s1_ar, s1_ai, s1_br, s1_bi;
  logic signed [TW-1:0] s1_wr, s1_wi;

  // Capture operands; scale 3 is folded to 2 here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inv   <= 1'b0;
      s1_shift <= 2'd0;
      s1_ar    <= '0;
      s1_ai    <= '0;
      s1_br    <= '0;
      s1_bi    <= '0;
      s1_wr    <= '0;
      s1_wi    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_inv   <= in_inv;
      s1_shift <= (in_scale == 2'd3) ? 2'd2 : in_scale;
      s1_ar    <= $signed(ar);
      s1_ai    <= $signed(ai);
      s1_br    <= $signed(br);
      s1_bi    <= $signed(bi);
      s1_wr    <= $signed(wr);
      s1_wi    <= $signed(wi);
    end
  end

  // ---------------- S2: full-precision products ----------------
  logic signed [PW-1:0] m_rr, m_ii, m_ri, m_ir;

  assign m_rr = PW'(s1_br) * PW'(s1_wr);
  assign m_ii = PW'(s1_bi) * PW'(s1_wi);
  assign m_ri = PW'(s1_br) * PW'(s1_wi);
  assign m_ir = PW'(s1_bi) * PW'(s1_wr);

  logic                 s2_valid;
  logic                 s2_inv;
  logic [1:0]           s2_shift;
  logic signed [DW-1:0] s2_ar, s2_ai;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  // Register the four partial products with A and tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_inv   <= 1'b0;
      s2_shift <= 2'd0;
      s2_ar    <= '0;
      s2_ai    <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_inv   <= s1_inv;
      s2_shift <= s1_shift;
      s2_ar    <= s1_ar;
      s2_ai    <= s1_ai;
      s2_rr    <= m_rr;
      s2_ii    <= m_ii;
      s2_ri    <= m_ri;
      s2_ir    <= m_ir;
    end
  end

  // ---------------- S3: Z, rounding, pre-scale sums ----------------
  logic signed [SW-1:0] zr_f, zi_f;
  logic signed [ZW-1:0] zr, zi;
  logic signed [FW-1:0] xf_r, xf_i, yf_r, yf_i;

  // Complex multiply combine; inverse mode conjugates W.
  always_comb begin
    zr_f = '0;
    zi_f = '0;
    unique case (1'b1)
      (!s2_inv): begin
        zr_f = SW'(s2_rr) - SW'(s2_ii);
        zi_f = SW'(s2_ri) + SW'(s2_ir);
      end
      (s2_inv): begin
        zr_f = SW'(s2_rr) + SW'(s2_ii);
        zi_f = SW'(s2_ir) - SW'(s2_ri);
      end
      default: ;
    endcase
  end

  assign zr = ZW'((zr_f + ZHALF) >>> (TW-1));
  assign zi = ZW'((zi_f + ZHALF) >>> (TW-1));

  assign xf_r = FW'(s2_ar) + FW'(zr);
  assign xf_i = FW'(s2_ai) + FW'(zi);
  assign yf_r = FW'(s2_ar) - FW'(zr);
  assign yf_i = FW'(s2_ai) - FW'(zi);

  logic                 s3_valid;
  logic [1:0]           s3_shift;
  logic signed [FW-1:0] s3_xr, s3_xi, s3_yr, s3_yi;

  // Register the unscaled sums.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_shift <= 2'd0;
      s3_xr    <= '0;
      s3_xi    <= '0;
      s3_yr    <= '0;
      s3_yi    <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_shift <= s2_shift;
      s3_xr    <= xf_r;
      s3_xi    <= xf_i;
      s3_yr    <= yf_r;
      s3_yi    <= yf_i;
    end
  end

  // ---------------- S4: scale, round, saturate ----------------
  // Returns {saturated, value}.
  function automatic logic [DW:0] fin(
    input logic signed [FW-1:0] f,
    input logic [1:0]           s
  );
    logic signed [VW-1:0] v;
    logic [DW:0]          r;
    v = VW'(f);
    unique case (1'b1)
      (s == 2'd1): v = (v + ONE) >>> 1;
      (s == 2'd2): v = (v + TWO) >>> 2;
      default: ;
    endcase
    if (v > MAXV)
      r = {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (v < MINV)
      r = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      r = {1'b0, DW'(v)};
    return r;
  endfunction

  logic [DW:0] f_xr, f_xi, f_yr, f_yi;

  assign f_xr = fin(s3_xr, s3_shift);
  assign f_xi = fin(s3_xi, s3_shift);
  assign f_yr = fin(s3_yr, s3_shift);
  assign f_yi = fin(s3_yi, s3_shift);

  // Output register; holds while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
      xr        <= '0;
      xi        <= '0;
      yr        <= '0;
      yi        <= '0;
    end else if (en) begin
      out_valid <= s3_valid;
      out_ovf   <= f_xr[DW] | f_xi[DW] | f_yr[DW] | f_yi[DW];
      xr        <= f_xr[DW-1:0];
      xi        <= f_xi[DW-1:0];
      yr        <= f_yr[DW-1:0];
      yi        <= f_yi[DW-1:0];
    end
  end

  // Sticky overflow: set on an overflowing handshake, set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_sticky <= 1'b0;
    else if (out_valid & out_ready & out_ovf)
      ovf_sticky <= 1'b1;
    else if (clr_ovf)
      ovf_sticky <= 1'b0;
  end

endmodule
